// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer: op encodings, FSM states
// and the result sign-fix helper.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } muldivStateE;

  function automatic logic isDivOp(logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic isSignedOp(logic [1:0] op);
    return ~op[0];
  endfunction

  // Returns {negate high part, negate low part}. A product is negated as one 2*WIDTH value,
  // so both bits agree for multiplies; a remainder takes the dividend's sign.
  function automatic logic [1:0] signFix(logic [1:0] op, logic signA, logic signB);
    if (op[1]) begin
      return {signA, signA ^ signB};
    end
    return {2{signA ^ signB}};
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// EX-stage <-> mul/div unit handshake and HI/LO read-back bundle.
interface muldiv_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             rd_req;
  logic             mt_we;
  logic             mt_sel;
  logic [WIDTH-1:0] mt_data;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, rd_req, mt_we, mt_sel, mt_data,
    input  busy, stall, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, rd_req, mt_we, mt_sel, mt_data,
    output busy, stall, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step, or (MULDIV_DIV_EN) restoring-divide step.
// acc holds {upper, lower}: {partial product, multiplier} or {remainder, quotient}.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               isDiv,
  input  logic [2*WIDTH-1:0] accIn,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] accOut
);
  logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   remShift;
  logic [WIDTH-1:0] diff;
`else
  logic unusedIsDiv;
  assign unusedIsDiv = isDiv;
`endif

  always_comb begin
    sum    = {1'b0, accIn[2*WIDTH-1:WIDTH]} + (accIn[0] ? {1'b0, operand} : '0);
    accOut = {sum, accIn[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    remShift = accIn[2*WIDTH-1:WIDTH-1];
    // True difference is below 2^WIDTH whenever it is taken, so modulo-WIDTH math suffices.
    diff     = remShift[WIDTH-1:0] - operand;
    if (isDiv) begin
      if (remShift >= {1'b0, operand}) begin
        accOut = {diff, accIn[WIDTH-2:0], 1'b1};
      end else begin
        accOut = {remShift[WIDTH-1:0], accIn[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end
endmodule

// File: rtl/muldiv_seq.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO; stalls EX while an operation is in flight.
// Divider hardware and div_zero are only built when MULDIV_DIV_EN is defined.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  muldiv_seq_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  muldivStateE        stateQ, stateD;
  logic [CntW-1:0]    cntQ, cntD;
  logic [2*WIDTH-1:0] accQ, accD, accStep, prodFix;
  logic [WIDTH-1:0]   operandQ, operandD, hiQ, hiD, loQ, loD, magA, magB;
  logic [1:0]         opQ, opD, fix;
  logic               signAQ, signAD, signBQ, signBD, divZeroQ, divZeroD, doneQ, doneD;
  logic               sa, sb, busy;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .isDiv   (isDivOp(opQ)),
    .accIn   (accQ),
    .operand (operandQ),
    .accOut  (accStep)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ   <= StIdle;
      cntQ     <= '0;
      accQ     <= '0;
      operandQ <= '0;
      opQ      <= '0;
      signAQ   <= 1'b0;
      signBQ   <= 1'b0;
      divZeroQ <= 1'b0;
      doneQ    <= 1'b0;
      hiQ      <= '0;
      loQ      <= '0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      accQ     <= accD;
      operandQ <= operandD;
      opQ      <= opD;
      signAQ   <= signAD;
      signBQ   <= signBD;
      divZeroQ <= divZeroD;
      doneQ    <= doneD;
      hiQ      <= hiD;
      loQ      <= loD;
    end
  end

  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    accD     = accQ;
    operandD = operandQ;
    opD      = opQ;
    signAD   = signAQ;
    signBD   = signBQ;
    divZeroD = divZeroQ;
    doneD    = 1'b0;
    hiD      = hiQ;
    loD      = loQ;
    sa       = isSignedOp(bus.op) & bus.src_a[WIDTH-1];
    sb       = isSignedOp(bus.op) & bus.src_b[WIDTH-1];
    magA     = sa ? -bus.src_a : bus.src_a;
    magB     = sb ? -bus.src_b : bus.src_b;
    fix      = signFix(opQ, signAQ, signBQ);
    prodFix  = fix[1] ? -accQ : accQ;

    unique case (stateQ)
      StIdle: begin
        if (bus.start) begin
          opD      = bus.op;
          cntD     = '0;
          divZeroD = 1'b0;
          signAD   = sa;
          signBD   = sb;
          if (isDivOp(bus.op)) begin
`ifdef MULDIV_DIV_EN
            if (bus.src_b == '0) begin
              // Skip the loop; FIX then writes HI=dividend, LO=all-ones unsigned.
              accD     = {bus.src_a, {WIDTH{1'b1}}};
              signAD   = 1'b0;
              signBD   = 1'b0;
              divZeroD = 1'b1;
              stateD   = StFix;
            end else begin
              accD     = {{WIDTH{1'b0}}, magA};
              operandD = magB;
              stateD   = StRun;
            end
`else
            stateD = StFix;
`endif
          end else begin
            accD     = {{WIDTH{1'b0}}, magB};
            operandD = magA;
            stateD   = StRun;
          end
        end else if (bus.mt_we) begin
          if (bus.mt_sel) hiD = bus.mt_data;
          else            loD = bus.mt_data;
        end
      end
      StRun: begin
        accD = accStep;
        cntD = cntQ + CntW'(1);
        if (cntQ == CntW'(WIDTH - 1)) stateD = StFix;
      end
      StFix: begin
        doneD  = 1'b1;
        stateD = StIdle;
        if (!isDivOp(opQ)) begin
          hiD = prodFix[2*WIDTH-1:WIDTH];
          loD = prodFix[WIDTH-1:0];
        end else begin
`ifdef MULDIV_DIV_EN
          hiD = fix[1] ? -accQ[2*WIDTH-1:WIDTH] : accQ[2*WIDTH-1:WIDTH];
          loD = fix[0] ? -accQ[WIDTH-1:0] : accQ[WIDTH-1:0];
`endif
        end
      end
      default: stateD = StIdle;
    endcase
  end

  assign busy         = (stateQ != StIdle);
  assign bus.busy     = busy;
  assign bus.stall    = busy & (bus.start | bus.rd_req | bus.mt_we);
  assign bus.done     = doneQ;
  assign bus.div_zero = divZeroQ;
  assign bus.hi       = hiQ;
  assign bus.lo       = loQ;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (WIDTH=32); divide checks follow MULDIV_DIV_EN.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  muldiv_seq_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; lat = edges after the accepting edge until done is seen (-1 on timeout).
  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic busyAfter);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    tick();
    bus.start = 1'b0;
    busyAfter = bus.busy;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0;
    bus.rd_req = 1'b1; bus.mt_we = 1'b0; bus.mt_sel = 1'b0; bus.mt_data = '0;
    tick(); tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", bus.stall); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b want=0", bus.div_zero); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", bus.lo); end
    reset = 1'b0;
    bus.rd_req = 1'b0;
    tick();
  endtask

  task automatic test_multu();
    int lat; logic bz;
    runOp(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bz);
    total++; if (bz !== 1'b1) begin bad++; $display("FAIL multu_busy got=%b want=1", bz); end
    total++; if (lat != 33) begin bad++; $display("FAIL multu_lat got=%0d want=33", lat); end
    total++; if (bus.hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_hi got=%h want=fffffffe", bus.hi); end
    total++; if (bus.lo !== 32'h00000001) begin bad++; $display("FAIL multu_lo got=%h want=00000001", bus.lo); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL multu_busy_done got=%b want=0", bus.busy); end
    tick();
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL multu_done_pulse got=%b want=0", bus.done); end
  endtask

  task automatic test_mult();
    int lat; logic bz;
    runOp(OP_MULT, 32'hFFFFFFF9, 32'h3, lat, bz);
    total++; if (lat != 33) begin bad++; $display("FAIL mult_lat got=%0d want=33", lat); end
    total++; if (bus.hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", bus.hi); end
    total++; if (bus.lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL mult_lo got=%h want=ffffffeb", bus.lo); end
    tick();
    runOp(OP_MULT, 32'h80000000, 32'h80000000, lat, bz);
    total++; if (bus.hi !== 32'h40000000) begin bad++; $display("FAIL mult_min_hi got=%h want=40000000", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL mult_min_lo got=%h want=0", bus.lo); end
  endtask

  task automatic test_back_to_back();
    int lat; logic bz;
    runOp(OP_MULT, 32'h00000005, 32'hFFFFFFFF, lat, bz);
    total++; if (bus.lo !== 32'hFFFFFFFB) begin bad++; $display("FAIL b2b_first_lo got=%h want=fffffffb", bus.lo); end
    // Next start presented in the done cycle itself.
    runOp(OP_MULTU, 32'h00010000, 32'h00010000, lat, bz);
    total++; if (bz !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", bz); end
    total++; if (lat != 33) begin bad++; $display("FAIL b2b_lat got=%0d want=33", lat); end
    total++; if (bus.hi !== 32'h1) begin bad++; $display("FAIL b2b_hi got=%h want=1", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL b2b_lo got=%h want=0", bus.lo); end
    tick();
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    int lat; logic bz;
    runOp(OP_DIV, 32'hFFFFFFF9, 32'h2, lat, bz);
    total++; if (lat != 33) begin bad++; $display("FAIL div_lat got=%0d want=33", lat); end
    total++; if (bus.lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo got=%h want=fffffffd", bus.lo); end
    total++; if (bus.hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi got=%h want=ffffffff", bus.hi); end
    runOp(OP_DIVU, 32'h7, 32'h0, lat, bz);
    total++; if (lat != 1) begin bad++; $display("FAIL divz_lat got=%0d want=1", lat); end
    total++; if (bus.hi !== 32'h7) begin bad++; $display("FAIL divz_hi got=%h want=7", bus.hi); end
    total++; if (bus.lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL divz_lo got=%h want=ffffffff", bus.lo); end
    total++; if (bus.div_zero !== 1'b1) begin bad++; $display("FAIL divz_flag got=%b want=1", bus.div_zero); end
    tick(); tick();
    total++; if (bus.div_zero !== 1'b1) begin bad++; $display("FAIL divz_sticky got=%b want=1", bus.div_zero); end
    runOp(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bz);
    total++; if (bus.lo !== 32'h80000000) begin bad++; $display("FAIL divmin_lo got=%h want=80000000", bus.lo); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL divmin_hi got=%h want=0", bus.hi); end
    total++; if (bus.div_zero !== 1'b0) begin bad++; $display("FAIL divmin_dz got=%b want=0", bus.div_zero); end
    runOp(OP_DIVU, 32'd100, 32'd7, lat, bz);
    total++; if (bus.lo !== 32'd14) begin bad++; $display("FAIL divu_lo got=%h want=e", bus.lo); end
    total++; if (bus.hi !== 32'd2) begin bad++; $display("FAIL divu_hi got=%h want=2", bus.hi); end
    tick();
  endtask
`else
  task automatic test_div();
    int lat; logic bz;
    // HI=1, LO=0 left over from the back-to-back multiply.
    runOp(OP_DIVU, 32'd100, 32'd7, lat, bz);
    total++; if (lat != 1) begin bad++; $display("FAIL divoff_lat got=%0d want=1", lat); end
    total++; if (bus.hi !== 32'h1) begin bad++; $display("FAIL divoff_hi got=%h want=1", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL divoff_lo got=%h want=0", bus.lo); end
    total++; if (bus.div_zero !== 1'b0) begin bad++; $display("FAIL divoff_dz got=%b want=0", bus.div_zero); end
    runOp(OP_DIV, 32'd5, 32'd0, lat, bz);
    total++; if (bus.div_zero !== 1'b0) begin bad++; $display("FAIL divoff_z_dz got=%b want=0", bus.div_zero); end
    tick();
  endtask
`endif

  task automatic test_mfhi_stall();
    int lat;
    bus.mt_we = 1'b1; bus.mt_sel = 1'b1; bus.mt_data = 32'h5555AAAA;
    tick();
    bus.mt_we = 1'b0;
    bus.rd_req = 1'b1;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL mfhi_idle_stall got=%b want=0", bus.stall); end
    total++; if (bus.hi !== 32'h5555AAAA) begin bad++; $display("FAIL mfhi_idle_hi got=%h want=5555aaaa", bus.hi); end
    bus.start = 1'b1; bus.op = OP_MULTU; bus.src_a = 32'd3; bus.src_b = 32'd5;
    tick();
    bus.start = 1'b0;
    lat = -1;
    for (int i = 0; i <= 40; i++) begin
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
      total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL mfhi_run_stall c=%0d got=%b want=1", i, bus.stall); end
      total++; if (bus.hi !== 32'h5555AAAA) begin bad++; $display("FAIL mfhi_run_hi c=%0d got=%h want=5555aaaa", i, bus.hi); end
      tick();
    end
    total++; if (lat != 33) begin bad++; $display("FAIL mfhi_lat got=%0d want=33", lat); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL mfhi_done_stall got=%b want=0", bus.stall); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL mfhi_res_hi got=%h want=0", bus.hi); end
    total++; if (bus.lo !== 32'd15) begin bad++; $display("FAIL mfhi_res_lo got=%h want=f", bus.lo); end
    bus.rd_req = 1'b0;
    tick();
  endtask

  task automatic test_mt();
    int lat; logic bz;
    bus.mt_we = 1'b1; bus.mt_sel = 1'b0; bus.mt_data = 32'h1234;
    tick();
    bus.mt_we = 1'b0;
    total++; if (bus.lo !== 32'h1234) begin bad++; $display("FAIL mtlo got=%h want=1234", bus.lo); end
    bus.mt_we = 1'b1; bus.mt_sel = 1'b1; bus.mt_data = 32'h9;
    tick();
    total++; if (bus.hi !== 32'h9) begin bad++; $display("FAIL mthi got=%h want=9", bus.hi); end
    bus.mt_we = 1'b0;
    bus.start = 1'b1; bus.op = OP_MULTU; bus.src_a = 32'd2; bus.src_b = 32'd3;
    tick();
    bus.start = 1'b0;
    bus.mt_data = 32'hDEAD; bus.mt_we = 1'b1;
    lat = -1;
    for (int i = 0; i <= 40; i++) begin
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
      if (i == 5) begin
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL mthi_run_stall got=%b want=1", bus.stall); end
      end
      tick();
    end
    bus.mt_we = 1'b0;
    total++; if (lat != 33) begin bad++; $display("FAIL mthi_run_lat got=%0d want=33", lat); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL mthi_run_hi got=%h want=0", bus.hi); end
    total++; if (bus.lo !== 32'h6) begin bad++; $display("FAIL mthi_run_lo got=%h want=6", bus.lo); end
    tick();
    // start and MTLO together: start wins, LO ends up as the product.
    bus.mt_we = 1'b1; bus.mt_sel = 1'b0; bus.mt_data = 32'hBEEF;
    runOp(OP_MULTU, 32'd1, 32'd1, lat, bz);
    bus.mt_we = 1'b0;
    total++; if (bus.lo !== 32'h1) begin bad++; $display("FAIL start_wins_lo got=%h want=1", bus.lo); end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat; logic bz;
    bus.mt_we = 1'b1; bus.mt_sel = 1'b1; bus.mt_data = 32'h77;
    tick();
    bus.mt_we = 1'b0;
    bus.start = 1'b1; bus.op = OP_MULT; bus.src_a = 32'hFFFFFFF9; bus.src_b = 32'd3;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    bus.rd_req = 1'b1;
    reset = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rstmid_stall got=%b want=0", bus.stall); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", bus.done); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL rstmid_hi got=%h want=0", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL rstmid_lo got=%h want=0", bus.lo); end
    tick();
    reset = 1'b0;
    bus.rd_req = 1'b0;
    tick();
    runOp(OP_MULT, 32'hFFFFFFF9, 32'd3, lat, bz);
    total++; if (lat != 33) begin bad++; $display("FAIL rstmid_lat got=%0d want=33", lat); end
    total++; if (bus.hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL rstmid_res_hi got=%h want=ffffffff", bus.hi); end
    total++; if (bus.lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL rstmid_res_lo got=%h want=ffffffeb", bus.lo); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_back_to_back();
    test_div();
    test_mfhi_stall();
    test_mt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the pipelined MIPS core. Accepts MULT/MULTU/DIV/DIVU from EX, runs a radix-2 shift-add / restoring-divide loop over WIDTH cycles, and owns the HI/LO registers. It raises a pipeline stall when a new mul/div, MFHI/MFLO or MTHI/MTLO reaches EX while an operation is in flight.

## Interface
- WIDTH, 32: operand/HI/LO width; must be even, ≥4.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  EX holds a mul/div instruction.
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- src_a  in  WIDTH  rs value (multiplicand/dividend).
- src_b  in  WIDTH  rt value (multiplier/divisor).
- rd_req  in  1  EX holds MFHI/MFLO.
- mt_we  in  1  EX holds MTHI/MTLO.
- mt_sel  in  1  0=LO, 1=HI (MTxx target).
- mt_data  in  WIDTH  MTxx write data.
- busy  out  1  operation in flight.
- stall  out  1  freeze IF/ID/EX, bubble into MEM.
- done  out  1  one-cycle pulse, HI/LO just updated.
- div_zero  out  1  sticky until next accepted start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX. Reset → IDLE; busy, stall, done, div_zero, hi, lo, counter, working regs all 0.
- IDLE, start=1: latch op; for signed ops store operand signs, convert operands to magnitudes; counter←0; → RUN. div_zero cleared.
- IDLE, DIV/DIVU with src_b=0: → FIX directly, no RUN; result HI=src_a, LO=all-ones; div_zero←1.
- RUN: one step per cycle, counter+1; → FIX after step WIDTH-1 (counter==WIDTH-1).
  - Multiply: if multiplier LSB, add multiplicand to upper accumulator half; shift {acc} right 1 with carry in.
  - Divide: shift {rem,quot} left 1; if rem ≥ divisor, subtract, set quot LSB.
- FIX: apply signs (product negated if sa^sb; quotient negated if sa^sb, remainder negated if sa); write HI/LO (mul: HI=upper, LO=lower; div: HI=remainder, LO=quotient); done←1 for one cycle; → IDLE.
- Arithmetic: product 2·WIDTH bits, no overflow; signed −2^(WIDTH−1) ÷ −1 gives LO=0x80000000 (WIDTH=32), HI=0, no flag.
- MTxx in IDLE with no start: write selected register at clock edge.
- stall = busy & (start | rd_req | mt_we), combinational. start/mt_we seen while busy ignored; pipeline re-presents them.
- IDLE, start & mt_we same cycle: start wins (decoder never issues both).
- hi/lo hold old values throughout RUN; MFHI issued in IDLE returns current value with no stall.

## Timing
- Start sampled at edge E0; busy high from E0 to E(WIDTH+1); HI/LO and done valid after edge E(WIDTH+1) (33 for WIDTH=32).
- Divide by zero: HI/LO, done after E1.
- Back-to-back: new start accepted in the done cycle (state IDLE) → zero-bubble issue.
- Reset mid-RUN/FIX: immediate abort, all outputs to reset values, no done pulse.

## Configuration
- MULDIV_DIV_EN defined: divider path and div_zero logic built as above.
- Undefined: only multiply hardware; DIV/DIVU accepted, complete via FIX after E1 with HI/LO unchanged, done pulses, div_zero tied 0.

## Structure
- muldiv_pkg: op encodings (OP_MULT..OP_DIVU), state enum, sign-fix helper function.
- Sub-module muldiv_step: combinational single iteration (add/shift or compare/subtract/shift), instanced once; muldiv_seq holds FSM, counter, HI/LO.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF → after E33 HI=0xFFFFFFFE, LO=0x00000001, done one cycle.
- MULT −7×3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV −7÷2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7÷0 → after E1 HI=7, LO=0xFFFFFFFF, div_zero=1.
- MFHI during RUN → stall=1 each cycle until done cycle, then 0; hi stable old value until E33.
- MTLO 0x1234 in IDLE → lo=0x1234 next cycle; MTHI during RUN → stalled, hi unchanged.
- Reset asserted at RUN counter=10 → busy/stall/done=0, hi=lo=0 immediately; new MULT afterwards completes normally.
